wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pending-write entries (power of 2, 2..16).
REQ-002 SHALL have port Clk  input  1  clock, all state updates on the positive edge.
REQ-003 SHALL have port Reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port InValid  input  1  producer offers a write.
REQ-005 SHALL have port InReady  output  1  queue accepts a write this cycle.
REQ-006 SHALL have port InReg  input  5  destination register address.
REQ-007 SHALL have port InData  input  32  destination register value.
REQ-008 SHALL have port Stall  input  1  high suppresses draining.
REQ-009 SHALL have port RegWrite  output  1  write enable to the register file.
REQ-010 SHALL have port WriteRegister  output  5  register file write address.
REQ-011 SHALL have port WriteData  output  32  register file write data.
REQ-012 SHALL have ports LookupReg1 and LookupReg2  input  5 each  addresses being read from the register file.
REQ-013 SHALL have ports Hit1 and Hit2  output  1 each  a pending entry matches the lookup.
REQ-014 SHALL have ports FwdData1 and FwdData2  output  32 each  data of the matching pending entry.
REQ-015 SHALL have port Count  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-016 SHALL store entries in a circular FIFO with head pointer, tail pointer and occupancy counter, pointers wrapping modulo DEPTH.
REQ-017 SHALL drive InReady = (Count < DEPTH) while Reset_n is high; full queue SHALL deassert InReady even if a pop occurs the same cycle (no pass-through).
REQ-018 SHALL accept a push on a rising edge where InValid and InReady are both 1.
REQ-019 SHALL discard, without enqueuing, any accepted push with InReg = 0; Count SHALL not change for it.
REQ-020 SHALL drive RegWrite = 1, WriteRegister = head InReg, WriteData = head InData combinationally when Count > 0 and Stall = 0.
REQ-021 SHALL pop the head on the rising edge where RegWrite = 1.
REQ-022 SHALL drive RegWrite = 0, WriteRegister = 0, WriteData = 0 when Count = 0 or Stall = 1.
REQ-023 SHALL make an entry pushed at edge N visible at RegWrite in the cycle after edge N (one-cycle latency), Stall permitting.
REQ-024 SHALL, on simultaneous push and pop, keep Count unchanged and advance both pointers.
REQ-025 SHALL never pop when empty and never push when full; Count SHALL stay within 0..DEPTH.
REQ-026 SHALL drive HitK = 1 and FwdDataK = data of the newest stored entry with InReg = LookupRegK, for K = 1, 2, purely combinationally.
REQ-027 SHALL drive HitK = 0 and FwdDataK = 0 when no stored entry matches or LookupRegK = 0.
REQ-028 SHALL include the head entry in the lookup during the cycle it is being drained.
REQ-029 SHALL exclude the same-cycle incoming push from the lookup.
REQ-030 SHALL drain entries strictly in arrival order; repeated writes to one register SHALL all reach the register file.

Reset
REQ-031 SHALL, on a rising edge with Reset_n = 0, clear Count, head and tail pointers to 0 and ignore InValid.
REQ-032 SHALL drive InReady = 0, RegWrite = 0, Hit1 = Hit2 = 0 while Reset_n = 0.
REQ-033 SHALL discard all pending entries on a reset mid-operation, without issuing their writes.
REQ-034 SHALL leave Count = 0, InReady = 1 and RegWrite = 0 on the first cycle after Reset_n returns high.

Verification
REQ-035 SHALL cover: reset, then push (InReg=5, InData=0xDEADBEEF) with Stall=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; Count 0 after following edge.
REQ-036 SHALL cover: Stall=1, push 4 entries (regs 1..4) -> Count=4, InReady=0, a fifth push is not accepted; release Stall -> regs 1,2,3,4 written on four consecutive cycles.
REQ-037 SHALL cover: Stall=1, push reg 7=0x11 then reg 7=0x22, LookupReg1=7 -> Hit1=1, FwdData1=0x22; LookupReg2=3 -> Hit2=0, FwdData2=0.
REQ-038 SHALL cover: push InReg=0, InData=0xFFFFFFFF -> Count stays 0, RegWrite stays 0; LookupReg1=0 -> Hit1=0.
REQ-039 SHALL cover: Count=2, simultaneous push and pop -> Count stays 2, pointers wrap correctly over 10 such cycles, order preserved.
REQ-040 SHALL cover: Count=3, Reset_n=0 for one edge -> Count=0, no RegWrite during or after reset, InReady=1 next cycle.

Source files
------------

// File: rtl/wb_write_queue.sv
// Posted register-write queue: buffers writes in a circular FIFO, drains the head
// into the register file when not stalled, and forwards the newest pending value to readers.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [4:0]               InReg,
    input  logic [31:0]              InData,
    input  logic                     Stall,
    output logic                     RegWrite,
    output logic [4:0]               WriteRegister,
    output logic [31:0]              WriteData,
    input  logic [4:0]               LookupReg1,
    input  logic [4:0]               LookupReg2,
    output logic                     Hit1,
    output logic                     Hit2,
    output logic [31:0]              FwdData1,
    output logic [31:0]              FwdData2,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    reg_mem_q  [DEPTH];
    logic [4:0]    reg_mem_d  [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];

    logic ready_s;
    logic pop_s;
    logic push_s;

    // Handshake qualifiers; a full queue refuses even when a pop frees a slot this cycle
    always_comb begin
        ready_s = Reset_n && (count_q < DEPTH_C);
        pop_s   = Reset_n && (count_q != {CW{1'b0}}) && !Stall;
        push_s  = InValid && ready_s && (InReg != 5'd0);
    end

    // Pointer and occupancy next state
    always_comb begin
        head_d = pop_s  ? (head_q + PW'(1)) : head_q;
        tail_d = push_s ? (tail_q + PW'(1)) : tail_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage next state: write the incoming entry at the tail
    always_comb begin
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        if (push_s) begin
            reg_mem_d[tail_q]  = InReg;
            data_mem_d[tail_q] = InData;
        end else begin
            reg_mem_d[tail_q]  = reg_mem_q[tail_q];
            data_mem_d[tail_q] = data_mem_q[tail_q];
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless outside the live window so no reset
    always_ff @(posedge Clk) begin
        reg_mem_q  <= reg_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Drain port and status
    always_comb begin
        InReady       = ready_s;
        Count         = count_q;
        RegWrite      = pop_s;
        WriteRegister = pop_s ? reg_mem_q[head_q]  : 5'd0;
        WriteData     = pop_s ? data_mem_q[head_q] : 32'd0;
    end

    // Forwarding: scan oldest to newest so the newest live match wins
    always_comb begin : lookup
        logic [PW-1:0] idx;
        logic          live;
        idx      = head_q;
        live     = 1'b0;
        Hit1     = 1'b0;
        Hit2     = 1'b0;
        FwdData1 = 32'd0;
        FwdData2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx  = head_q + PW'(i);
            live = Reset_n && (CW'(i) < count_q);
            Hit1     = (live && (LookupReg1 != 5'd0) && (reg_mem_q[idx] == LookupReg1)) ? 1'b1 : Hit1;
            FwdData1 = (live && (LookupReg1 != 5'd0) && (reg_mem_q[idx] == LookupReg1)) ? data_mem_q[idx] : FwdData1;
            Hit2     = (live && (LookupReg2 != 5'd0) && (reg_mem_q[idx] == LookupReg2)) ? 1'b1 : Hit2;
            FwdData2 = (live && (LookupReg2 != 5'd0) && (reg_mem_q[idx] == LookupReg2)) ? data_mem_q[idx] : FwdData2;
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset_n, InValid, Stall;
    logic [4:0]  InReg, LookupReg1, LookupReg2;
    logic [31:0] InData;
    logic        InReady, RegWrite, Hit1, Hit2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData, FwdData1, FwdData2;
    logic [2:0]  Count;

    int errors = 0;
    int checks = 0;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InReg(InReg), .InData(InData), .Stall(Stall), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .LookupReg1(LookupReg1), .LookupReg2(LookupReg2), .Hit1(Hit1), .Hit2(Hit2),
        .FwdData1(FwdData1), .FwdData2(FwdData2), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        InValid = 1'b1; InReg = r; InData = d;
        tick();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; InValid = 1'b1; InReg = 5'd9; InData = 32'd1; LookupReg1 = 5'd9;
        tick();
        #1;
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", InReady); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got=%0b exp=0", RegWrite); end
        checks++; if (Hit1 !== 1'b0) begin errors++; $display("FAIL rst_hit1 got=%0b exp=0", Hit1); end
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", Count); end
        tick();
        Reset_n = 1'b1; InValid = 1'b0; LookupReg1 = 5'd0;
        #1;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL post_rst_count got=%0d exp=0", Count); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%0b exp=1", InReady); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL post_rst_regwrite got=%0b exp=0", RegWrite); end
        tick();
    endtask

    task automatic test_single();
        Stall = 1'b0;
        push(5'd5, 32'hDEADBEEF);
        #1;
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_rw got=%0b exp=1", RegWrite); end
        checks++; if (WriteRegister !== 5'd5) begin errors++; $display("FAIL single_reg got=%0d exp=5", WriteRegister); end
        checks++; if (WriteData !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", WriteData); end
        tick();
        #1;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL single_count got=%0d exp=0", Count); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_full_stall();
        Stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + i);
        #1;
        checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", Count); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", InReady); end
        checks++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
            errors++; $display("FAIL stall_outputs rw=%0b reg=%0d data=%h exp 0", RegWrite, WriteRegister, WriteData); end
        push(5'd9, 32'h999);
        #1;
        checks++; if (Count !== 3'd4) begin errors++; $display("FAIL fifth_push count=%0d exp=4", Count); end
        Stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 32'h100 + i) begin
                errors++; $display("FAIL drain_%0d rw=%0b reg=%0d data=%h", i, RegWrite, WriteRegister, WriteData); end
            tick();
        end
        #1;
        checks++; if (Count !== 3'd0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL drain_end count=%0d rw=%0b exp 0/0", Count, RegWrite); end
    endtask

    task automatic test_forward();
        Stall = 1'b1;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        InValid = 1'b1; InReg = 5'd3; InData = 32'h33; LookupReg1 = 5'd7; LookupReg2 = 5'd3;
        #1;
        checks++; if (Hit1 !== 1'b1 || FwdData1 !== 32'h22) begin errors++; $display("FAIL fwd_newest hit=%0b data=%h exp 1/22", Hit1, FwdData1); end
        checks++; if (Hit2 !== 1'b0 || FwdData2 !== 32'd0) begin errors++; $display("FAIL fwd_incoming hit=%0b data=%h exp 0/0", Hit2, FwdData2); end
        tick();
        InValid = 1'b0;
        #1;
        checks++; if (Hit2 !== 1'b1 || FwdData2 !== 32'h33) begin errors++; $display("FAIL fwd_stored hit=%0b data=%h exp 1/33", Hit2, FwdData2); end
        Stall = 1'b0;
        #1;
        checks++; if (WriteData !== 32'h11 || Hit1 !== 1'b1 || FwdData1 !== 32'h22) begin
            errors++; $display("FAIL fwd_drain1 wd=%h hit=%0b fwd=%h", WriteData, Hit1, FwdData1); end
        tick();
        #1;
        checks++; if (WriteData !== 32'h22 || Hit1 !== 1'b1 || FwdData1 !== 32'h22) begin
            errors++; $display("FAIL fwd_head_drain wd=%h hit=%0b fwd=%h", WriteData, Hit1, FwdData1); end
        tick();
        #1;
        checks++; if (Hit1 !== 1'b0 || FwdData1 !== 32'd0 || Hit2 !== 1'b1) begin
            errors++; $display("FAIL fwd_after hit1=%0b fwd1=%h hit2=%0b", Hit1, FwdData1, Hit2); end
        tick();
        #1;
        checks++; if (Count !== 3'd0 || Hit2 !== 1'b0) begin errors++; $display("FAIL fwd_empty count=%0d hit2=%0b", Count, Hit2); end
        LookupReg1 = 5'd0; LookupReg2 = 5'd0;
    endtask

    task automatic test_zero_reg();
        Stall = 1'b0; LookupReg1 = 5'd0;
        InValid = 1'b1; InReg = 5'd0; InData = 32'hFFFFFFFF;
        #1;
        checks++; if (Hit1 !== 1'b0) begin errors++; $display("FAIL zero_hit got=%0b exp=0", Hit1); end
        tick();
        InValid = 1'b0;
        #1;
        checks++; if (Count !== 3'd0 || RegWrite !== 1'b0 || Hit1 !== 1'b0) begin
            errors++; $display("FAIL zero_reg count=%0d rw=%0b hit=%0b exp 0", Count, RegWrite, Hit1); end
    endtask

    task automatic test_back_to_back();
        Stall = 1'b1;
        push(5'd10, 32'hA00A);
        push(5'd11, 32'hA00B);
        Stall = 1'b0;
        for (int k = 0; k < 10; k++) begin
            InValid = 1'b1; InReg = 5'(12 + k); InData = 32'hA000 + 32'(12 + k);
            #1;
            checks++; if (Count !== 3'd2 || RegWrite !== 1'b1 || WriteRegister !== 5'(10 + k) || WriteData !== 32'hA000 + 32'(10 + k)) begin
                errors++; $display("FAIL b2b_%0d count=%0d rw=%0b reg=%0d data=%h", k, Count, RegWrite, WriteRegister, WriteData); end
            tick();
        end
        InValid = 1'b0;
        for (int k = 20; k < 22; k++) begin
            #1;
            checks++; if (WriteRegister !== 5'(k) || WriteData !== 32'hA000 + 32'(k)) begin
                errors++; $display("FAIL b2b_tail reg=%0d data=%h exp %0d", WriteRegister, WriteData, k); end
            tick();
        end
        #1;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL b2b_empty count=%0d exp=0", Count); end
    endtask

    task automatic test_reset_mid();
        Stall = 1'b1;
        push(5'd21, 32'h21);
        push(5'd22, 32'h22);
        push(5'd23, 32'h23);
        #1;
        checks++; if (Count !== 3'd3) begin errors++; $display("FAIL mid_count got=%0d exp=3", Count); end
        Reset_n = 1'b0; Stall = 1'b0; InValid = 1'b1; InReg = 5'd5;
        #1;
        checks++; if (RegWrite !== 1'b0 || InReady !== 1'b0) begin errors++; $display("FAIL mid_during rw=%0b ready=%0b exp 0/0", RegWrite, InReady); end
        tick();
        Reset_n = 1'b1; InValid = 1'b0;
        #1;
        checks++; if (Count !== 3'd0 || InReady !== 1'b1 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL mid_after count=%0d ready=%0b rw=%0b", Count, InReady, RegWrite); end
        tick();
        #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL mid_later rw=%0b exp=0", RegWrite); end
    endtask

    task automatic test_random(input int n);
        logic [4:0]  mreg[$];
        logic [31:0] mdat[$];
        logic        e_ready, e_rw, e_hit1, e_hit2;
        logic [4:0]  e_wr;
        logic [31:0] e_wd, e_fwd1, e_fwd2;
        for (int c = 0; c < n; c++) begin
            Reset_n    = (c == 0 || $urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            Stall      = ($urandom_range(0, 2) == 0);
            InValid    = ($urandom_range(0, 2) != 0);
            InReg      = 5'($urandom_range(0, 7));
            InData     = $urandom;
            LookupReg1 = 5'($urandom_range(0, 7));
            LookupReg2 = 5'($urandom_range(0, 7));
            #1;
            e_ready = Reset_n && (mreg.size() < DEPTH);
            e_rw    = Reset_n && (mreg.size() > 0) && !Stall;
            e_wr    = e_rw ? mreg[0] : 5'd0;
            e_wd    = e_rw ? mdat[0] : 32'd0;
            e_hit1 = 1'b0; e_fwd1 = 32'd0; e_hit2 = 1'b0; e_fwd2 = 32'd0;
            for (int k = 0; k < mreg.size(); k++) begin
                if (Reset_n && LookupReg1 != 5'd0 && mreg[k] == LookupReg1) begin e_hit1 = 1'b1; e_fwd1 = mdat[k]; end
                if (Reset_n && LookupReg2 != 5'd0 && mreg[k] == LookupReg2) begin e_hit2 = 1'b1; e_fwd2 = mdat[k]; end
            end
            if (c > 0) begin
                checks++; if (Count !== 3'(mreg.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, Count, mreg.size()); end
                checks++; if (InReady !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, InReady, e_ready); end
                checks++; if (RegWrite !== e_rw) begin errors++; $display("FAIL rnd_rw c=%0d got=%0b exp=%0b", c, RegWrite, e_rw); end
                checks++; if (WriteRegister !== e_wr || WriteData !== e_wd) begin
                    errors++; $display("FAIL rnd_wr c=%0d got=%0d/%h exp=%0d/%h", c, WriteRegister, WriteData, e_wr, e_wd); end
                checks++; if (Hit1 !== e_hit1 || FwdData1 !== e_fwd1) begin
                    errors++; $display("FAIL rnd_lk1 c=%0d got=%0b/%h exp=%0b/%h", c, Hit1, FwdData1, e_hit1, e_fwd1); end
                checks++; if (Hit2 !== e_hit2 || FwdData2 !== e_fwd2) begin
                    errors++; $display("FAIL rnd_lk2 c=%0d got=%0b/%h exp=%0b/%h", c, Hit2, FwdData2, e_hit2, e_fwd2); end
            end
            if (!Reset_n) begin
                mreg.delete(); mdat.delete();
            end else begin
                if (e_rw) begin void'(mreg.pop_front()); void'(mdat.pop_front()); end
                if (InValid && e_ready && InReg != 5'd0) begin mreg.push_back(InReg); mdat.push_back(InData); end
            end
            tick();
        end
        Reset_n = 1'b1; InValid = 1'b0; Stall = 1'b0; LookupReg1 = 5'd0; LookupReg2 = 5'd0;
    endtask

    initial begin
        Reset_n = 1'b0; InValid = 1'b0; Stall = 1'b0; InReg = 5'd0; InData = 32'd0;
        LookupReg1 = 5'd0; LookupReg2 = 5'd0;
        @(negedge Clk);
        test_reset();
        test_single();
        test_full_stall();
        test_forward();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_random(600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
